// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO.
// Used by sync_fifo_if, sync_fifo_mem and sync_fifo.
package sync_fifo_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 16;

    // Pointer width for a power-of-two depth; a single-bit pointer is the minimum.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Producer/consumer handshake bundle for sync_fifo.
// Optional overflow/underflow signals exist only when SYNC_FIFO_ERR_EN is defined.
interface sync_fifo_if
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic [WIDTH-1:0] data_in;
    logic             write_en;
    logic             read_en;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;

`ifdef SYNC_FIFO_ERR_EN
    logic             overflow;
    logic             underflow;

    modport master (
        output data_in, write_en, read_en,
        input  data_out, full, empty, overflow, underflow
    );

    modport slave (
        input  data_in, write_en, read_en,
        output data_out, full, empty, overflow, underflow
    );
`else
    modport master (
        output data_in, write_en, read_en,
        input  data_out, full, empty
    );

    modport slave (
        input  data_in, write_en, read_en,
        output data_out, full, empty
    );
`endif

endinterface

// File: rtl/sync_fifo_mem.sv
// DEPTH x WIDTH dual-port storage: one write port, one registered read port.
// Only the read register is reset; the array itself keeps its contents.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, occupancy counter and flags around sync_fifo_mem.
// Define SYNC_FIFO_ERR_EN to add sticky overflow/underflow outputs.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    sync_fifo_if.slave  bus
);

    localparam int AW = ptr_width(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             full_w;
    logic             empty_w;
    logic             wr_acc;
    logic             rd_acc;
    logic [WIDTH-1:0] rd_data;

    // Flags decode straight from the registered count, so they track the post-edge occupancy.
    assign full_w  = (count == CNT_FULL);
    assign empty_w = (count == '0);
    assign wr_acc  = bus.write_en && !full_w;
    assign rd_acc  = bus.read_en  && !empty_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    sync_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_acc && !rst),
        .wr_addr (wr_ptr),
        .wr_data (bus.data_in),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    assign bus.data_out = rd_data;
    assign bus.full     = full_w;
    assign bus.empty    = empty_w;

`ifdef SYNC_FIFO_ERR_EN
    logic overflow_q;
    logic underflow_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (bus.write_en && full_w) begin
                overflow_q <= 1'b1;
            end
            if (bus.read_en && empty_w) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo (WIDTH=16, DEPTH=16).
// Also checks overflow/underflow when built with SYNC_FIFO_ERR_EN.
module tb_sync_fifo;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    sync_fifo_if #(.WIDTH(16)) bus ();

    sync_fifo #(
        .WIDTH (16),
        .DEPTH (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given request; inputs return idle and outputs are settled afterwards.
    task automatic cyc(input logic we, input logic re, input logic [15:0] din);
        bus.write_en = we;
        bus.read_en  = re;
        bus.data_in  = din;
        @(posedge clk);
        #1;
        bus.write_en = 1'b0;
        bus.read_en  = 1'b0;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        bus.write_en = 1'b0;
        bus.read_en  = 1'b0;
        bus.data_in  = '0;

        // reset then idle
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_dout", 32'(bus.data_out), 32'h0);
        cyc(1'b0, 1'b1, 16'h0);
        chk("idle_rd_dout", 32'(bus.data_out), 32'h0);
        chk("idle_rd_empty", 32'(bus.empty), 32'd1);
`ifdef SYNC_FIFO_ERR_EN
        chk("idle_underflow", 32'(bus.underflow), 32'd1);
        chk("idle_overflow", 32'(bus.overflow), 32'd0);
`endif

        // fill 0x0001..0x0010
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b1, 1'b0, 16'(i));
            if (i == 1)  chk("fill_not_empty", 32'(bus.empty), 32'd0);
            if (i == 15) chk("fill15_full", 32'(bus.full), 32'd0);
        end
        chk("fill16_full", 32'(bus.full), 32'd1);
        cyc(1'b1, 1'b0, 16'hBEEF);
        chk("ovf_full", 32'(bus.full), 32'd1);
`ifdef SYNC_FIFO_ERR_EN
        chk("ovf_flag", 32'(bus.overflow), 32'd1);
`endif

        // drain in order
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b0, 1'b1, 16'h0);
            chk($sformatf("drain_%0d", i), 32'(bus.data_out), 32'(i));
            if (i == 1)  chk("drain_full_drop", 32'(bus.full), 32'd0);
            if (i == 15) chk("drain15_empty", 32'(bus.empty), 32'd0);
        end
        chk("drain_empty", 32'(bus.empty), 32'd1);
        cyc(1'b0, 1'b1, 16'h0);
        chk("udf_hold", 32'(bus.data_out), 32'h0010);
        chk("udf_empty", 32'(bus.empty), 32'd1);

        // wrap-around
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 16'(16'h0020 + i));
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b1, 16'h0);
            chk($sformatf("wrapA_%0d", i), 32'(bus.data_out), 32'(16'h0020 + i));
        end
        for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, 16'(16'h0100 + i));
        for (int i = 0; i < 12; i++) begin
            cyc(1'b0, 1'b1, 16'h0);
            chk($sformatf("wrapB_%0d", i), 32'(bus.data_out), 32'(16'h0100 + i));
        end
        chk("wrap_empty", 32'(bus.empty), 32'd1);

        // simultaneous read/write with 5 stored
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 16'(16'h0200 + i));
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b1, 16'(16'h0300 + i));
            chk($sformatf("simul_%0d", i), 32'(bus.data_out),
                (i < 5) ? 32'(16'h0200 + i) : 32'(16'h0300 + i - 5));
            chk($sformatf("simul_flags_%0d", i), {30'd0, bus.full, bus.empty}, 32'd0);
        end
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, 16'h0);
            chk($sformatf("simul_drain_%0d", i), 32'(bus.data_out), 32'(16'h0303 + i));
        end
        chk("simul_count5_empty", 32'(bus.empty), 32'd1);

        // simultaneous while full: read only
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 16'(16'h0400 + i));
        chk("full_again", 32'(bus.full), 32'd1);
        cyc(1'b1, 1'b1, 16'hAAAA);
        chk("full_simul_dout", 32'(bus.data_out), 32'h0400);
        chk("full_simul_full", 32'(bus.full), 32'd0);
        for (int i = 1; i < 16; i++) begin
            cyc(1'b0, 1'b1, 16'h0);
            chk($sformatf("full_drain_%0d", i), 32'(bus.data_out), 32'(16'h0400 + i));
        end
        chk("full_drain_empty", 32'(bus.empty), 32'd1);

        // simultaneous while empty: write only, no write-through
        cyc(1'b1, 1'b1, 16'h5555);
        chk("empty_simul_dout", 32'(bus.data_out), 32'h040F);
        chk("empty_simul_empty", 32'(bus.empty), 32'd0);
        cyc(1'b0, 1'b1, 16'h0);
        chk("empty_simul_rd", 32'(bus.data_out), 32'h5555);
        chk("empty_simul_end", 32'(bus.empty), 32'd1);

        // reset mid-stream, with a write request pending to test priority
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 16'(16'h0600 + i));
        rst = 1'b1;
        cyc(1'b1, 1'b1, 16'h9999);
        rst = 1'b0;
        chk("mid_rst_empty", 32'(bus.empty), 32'd1);
        chk("mid_rst_full", 32'(bus.full), 32'd0);
        chk("mid_rst_dout", 32'(bus.data_out), 32'h0);
`ifdef SYNC_FIFO_ERR_EN
        chk("mid_rst_ovf", 32'(bus.overflow), 32'd0);
        chk("mid_rst_udf", 32'(bus.underflow), 32'd0);
`endif
        cyc(1'b1, 1'b0, 16'h1234);
        chk("post_rst_wr", 32'(bus.empty), 32'd0);
        cyc(1'b0, 1'b1, 16'h0);
        chk("post_rst_rd", 32'(bus.data_out), 32'h1234);
        chk("post_rst_empty", 32'(bus.empty), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Single-clock synchronous FIFO that buffers WIDTH-bit words between a producer and a consumer in the same clock domain.
- Write side: write_en and data_in, throttled by full. Read side: read_en, throttled by empty, with a registered data_out.
- General-purpose buffer for datapath decoupling; no clock-domain crossing.

Parameters:
- WIDTH, 16, data word width in bits (>=1).
- DEPTH, 16, number of storage entries; power of two, >=2.
- AW, $clog2(DEPTH), derived localparam: pointer width. Occupancy counter is AW+1 bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- data_in  in  WIDTH  write data, sampled on the clk edge when the write is accepted.
- write_en  in  1  write request.
- read_en  in  1  read request.
- data_out  out  WIDTH  registered read data.
- full  out  1  high when occupancy == DEPTH.
- empty  out  1  high when occupancy == 0.

Behaviour:
- Reset (rst=1 at a clk edge), including mid-operation:
  - wr_ptr=0, rd_ptr=0, count=0.
  - data_out=0, full=0, empty=1.
  - Storage array contents are not cleared.
  - rst has priority over write_en and read_en.
- Write accept: wr_acc = write_en && !full.
  - On accept: mem[wr_ptr] <= data_in; wr_ptr increments modulo DEPTH.
  - write_en while full is ignored: no state change, data is dropped.
- Read accept: rd_acc = read_en && !empty.
  - On accept: data_out <= mem[rd_ptr]; rd_ptr increments modulo DEPTH.
  - Read latency: data is valid on data_out after the same edge that accepts the read.
  - data_out holds its last value when no read is accepted, including read_en while empty.
- Occupancy count:
  - +1 on wr_acc only; -1 on rd_acc only; unchanged when both or neither.
- Simultaneous read and write, each gated by its own flag evaluated before the edge:
  - Full: only the read proceeds. Next state count=DEPTH-1, full=0.
  - Empty: only the write proceeds. No write-through to data_out; data_out holds.
  - Otherwise: both proceed; count and flags are unchanged.
- full and empty are registered, or decoded combinationally from the registered count. Either way they reflect the post-edge occupancy; no glitches relative to clk.
- Pointer wrap: DEPTH is a power of two, so pointers roll over naturally from DEPTH-1 to 0.
- Order: strictly first-in-first-out; no data reordering or duplication.

Optional Feature:
- Macro SYNC_FIFO_ERR_EN.
- When defined, add two output ports:
  - overflow (1 bit): sticky; set on any edge with write_en && full.
  - underflow (1 bit): sticky; set on any edge with read_en && empty.
  - Both are cleared only by rst.
- When not defined, neither port nor its logic exists, and the interface is exactly as listed above.

Decomposition:
- Shared package sync_fifo_pkg:
  - Default WIDTH/DEPTH constants.
  - A clog2-based pointer-width helper.
- One natural sub-module: sync_fifo_mem, a simple dual-port RAM with one write port and a registered read port, DEPTH x WIDTH.
- The top level holds pointers, the counter, the flags and the optional error logic.

Test Plan:
- Reset then idle: after rst=1 for 2 edges -> empty=1, full=0, data_out=0; read_en=1 with no writes -> data_out stays 0, empty stays 1.
- Fill: write 16 words 0x0001..0x0010 on back-to-back edges -> full=1 after the 16th edge. A 17th write of 0xBEEF is dropped; with SYNC_FIFO_ERR_EN, overflow=1.
- Drain: from full, read_en=1 for 16 edges -> data_out equals 0x0001..0x0010 in order, each one edge after its accepting read. empty=1 after the 16th read; a 17th read leaves data_out=0x0010.
- Wrap-around: write 10, read 10, then write 12 (0x0100..0x010B) and read 12 -> exact order returned across the pointer wrap; empty=1 at the end.
- Simultaneous: with 5 entries stored, write_en=read_en=1 for 8 edges -> count stays 5, flags unchanged, reads return the oldest data. When full, simultaneous read/write -> only the read happens, full drops to 0.
- Reset mid-stream: with 7 entries, assert rst for 1 edge -> empty=1, data_out=0; the next write of 0x1234 followed by a read returns 0x1234.
